lsu: RTL and testbench

Load/store unit of the RV64 core, sitting directly downstream of the ALU. It takes the ALU-computed effective address, RS2 store data and funct3 from the control unit. It runs one single-phase valid/ready transaction on the data-memory bus, using byte-lane steering and write strobes, and returns sign- or zero-extended load data to the write-back mux. A multi-cycle FSM with a timeout counter lets the core stall on slow memory instead of assuming a combinational MEM.

---
 rtl/lsu_if.sv | 48 ++++
 rtl/lsu.sv | 207 ++++++++++++++++++++
 tb/tb_lsu.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// lsu_if.sv - bus bundles around the load/store unit.
//   lsu_req_if : control-unit request / write-back response side
//                (master = core, slave = lsu)
//   lsu_mem_if : single-phase valid/ready data-memory bus
//                (master = lsu, slave = memory)

interface lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_err;
    logic        busy;

    modport master (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err, busy
    );

    modport slave (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err, busy
    );
endinterface

interface lsu_mem_if;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_rdata;

    modport master (
        output mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/lsu.sv
// lsu.sv - RV64 load/store unit.
// Accepts one memory op from the control unit, runs a single valid/ready
// transaction on the data bus with byte-lane steering and write strobes,
// and returns sign/zero-extended load data. A BUS-state timeout counter
// aborts accesses to unresponsive memory.
//
// Build option: define LSU_MISALIGN_TRAP_EN to turn misaligned accesses
// into errors; otherwise the offset is rounded down to size alignment.

module lsu #(
    parameter int TIMEOUT = 255
) (
    input  logic      clk,
    input  logic      rst,
    lsu_req_if.slave  req,
    lsu_mem_if.master mem
);

    localparam int               CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LIMIT = CNT_W'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] tmo_cnt;

    logic             mem_valid_q;
    logic             mem_we_q;
    logic [63:0]      mem_addr_q;
    logic [63:0]      mem_wdata_q;
    logic [7:0]       mem_wstrb_q;
    logic             resp_valid_q;
    logic             resp_err_q;
    logic [63:0]      resp_rdata_q;

    // Request fields kept for the BUS state (data only, never reset)
    logic             lat_we;
    logic [2:0]       lat_func3;
    logic [2:0]       lat_off;

    logic             req_bad;
    logic [2:0]       eff_off;

    // Round a byte offset down to the natural alignment of the access size
    function automatic logic [2:0] align_off(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    align_off = off;
            2'd1:    align_off = {off[2:1], 1'b0};
            2'd2:    align_off = {off[2], 2'b00};
            default: align_off = 3'd0;
        endcase
    endfunction

`ifdef LSU_MISALIGN_TRAP_EN
    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
        misaligned = (align_off(size, off) != off);
    endfunction
`endif

    // Byte-lane write strobes for a store of the given size at the given offset
    function automatic logic [7:0] lane_strobe(input logic [1:0] size, input logic [2:0] off);
        case (size)
            2'd0:    lane_strobe = 8'h01 << off;
            2'd1:    lane_strobe = 8'h03 << off;
            2'd2:    lane_strobe = 8'h0F << off;
            default: lane_strobe = 8'hFF;
        endcase
    endfunction

    // Shift the addressed lanes down, truncate to size, then extend to 64 bits
    function automatic logic [63:0] extend_load(input logic [63:0] raw,
                                                input logic [2:0]  func3,
                                                input logic [2:0]  off);
        logic        [63:0] sh;
        logic signed [63:0] sx;
        logic        [63:0] zx;
        sh = raw >> {off, 3'b000};
        case (func3[1:0])
            2'd0: begin
                sx = 64'($signed(sh[7:0]));
                zx = {56'd0, sh[7:0]};
            end
            2'd1: begin
                sx = 64'($signed(sh[15:0]));
                zx = {48'd0, sh[15:0]};
            end
            2'd2: begin
                sx = 64'($signed(sh[31:0]));
                zx = {32'd0, sh[31:0]};
            end
            default: begin
                sx = $signed(sh);
                zx = sh;
            end
        endcase
        extend_load = func3[2] ? zx : sx;
    endfunction

    // Decode legality of the incoming request and its effective lane offset
    always_comb begin
        req_bad = req.req_we ? req.req_func3[2] : (req.req_func3 == 3'b111);
`ifdef LSU_MISALIGN_TRAP_EN
        eff_off = req.req_addr[2:0];
        if (misaligned(req.req_func3[1:0], req.req_addr[2:0])) begin
            req_bad = 1'b1;
        end
`else
        eff_off = align_off(req.req_func3[1:0], req.req_addr[2:0]);
`endif
    end

    // Capture the accepted request's fields for use while the bus cycle runs
    always_ff @(posedge clk) begin
        if (state == IDLE && req.req_valid) begin
            lat_we    <= req.req_we;
            lat_func3 <= req.req_func3;
            lat_off   <= eff_off;
        end
    end

    // Main FSM: IDLE -> (BUS) -> RESP -> IDLE, with registered bus and response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            tmo_cnt      <= '0;
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 64'd0;
            mem_wdata_q  <= 64'd0;
            mem_wstrb_q  <= 8'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 64'd0;
        end else begin
            resp_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 64'd0;
                    if (req.req_valid) begin
                        if (req_bad) begin
                            state        <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                        end else begin
                            state       <= BUS;
                            tmo_cnt     <= '0;
                            mem_valid_q <= 1'b1;
                            mem_we_q    <= req.req_we;
                            mem_addr_q  <= {req.req_addr[63:3], 3'b000};
                            mem_wdata_q <= req.req_wdata << {eff_off, 3'b000};
                            mem_wstrb_q <= req.req_we ? lane_strobe(req.req_func3[1:0], eff_off)
                                                      : 8'd0;
                        end
                    end
                end
                BUS: begin
                    if (mem.mem_ready) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= lat_we ? 64'd0
                                               : extend_load(mem.mem_rdata, lat_func3, lat_off);
                        mem_valid_q  <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_wstrb_q  <= 8'd0;
                    end else if (tmo_cnt == TMO_LIMIT) begin
                        state        <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b1;
                        resp_rdata_q <= 64'd0;
                        mem_valid_q  <= 1'b0;
                        mem_we_q     <= 1'b0;
                        mem_wstrb_q  <= 8'd0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RESP: begin
                    state        <= IDLE;
                    resp_err_q   <= 1'b0;
                    resp_rdata_q <= 64'd0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign req.req_ready  = (state == IDLE) && !rst;
    assign req.busy       = (state != IDLE);
    assign req.resp_valid = resp_valid_q;
    assign req.resp_err   = resp_err_q;
    assign req.resp_rdata = resp_rdata_q;

    assign mem.mem_valid  = mem_valid_q;
    assign mem.mem_we     = mem_we_q;
    assign mem.mem_addr   = mem_addr_q;
    assign mem.mem_wdata  = mem_wdata_q;
    assign mem.mem_wstrb  = mem_wstrb_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu.sv - self-checking bench for lsu: directed cases plus random ops
// compared against a behavioural model of the load/store rules.

module tb_lsu;

    localparam int TIMEOUT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lsu_req_if req_if ();
    lsu_mem_if mem_if ();

    lsu #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .req (req_if),
        .mem (mem_if)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int size_bytes(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic int model_off(input logic [63:0] addr, input logic [2:0] f3);
        int o;
        int nb;
        o  = int'(addr[2:0]);
        nb = size_bytes(f3);
`ifdef LSU_MISALIGN_TRAP_EN
        return o;
`else
        return o - (o % nb);
`endif
    endfunction

    function automatic logic model_illegal(input logic we, input logic [2:0] f3,
                                           input logic [63:0] addr);
        logic bad;
        bad = we ? (f3 >= 3'd4) : (f3 == 3'd7);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((int'(addr[2:0]) % size_bytes(f3)) != 0) bad = 1'b1;
`else
        if (addr == 64'd1) bad = bad;
`endif
        return bad;
    endfunction

    function automatic logic [7:0] model_strobe(input logic [2:0] f3, input int o);
        int s;
        s = ((1 << size_bytes(f3)) - 1) << o;
        return 8'(s);
    endfunction

    function automatic logic [63:0] model_load(input logic [63:0] rd, input logic [2:0] f3,
                                               input int o);
        int          nb;
        logic [63:0] mask;
        logic [63:0] v;
        nb   = size_bytes(f3);
        mask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * nb)) - 64'd1);
        v    = (rd >> (8 * o)) & mask;
        if (!f3[2] && nb < 8 && v[8 * nb - 1]) v = v | ~mask;
        return v;
    endfunction

    // One complete operation; delay = BUS cycles with mem_ready low before it rises
    // (delay > TIMEOUT means memory never answers).
    task automatic run_op(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                          input logic [63:0] wdata, input logic [63:0] rdata, input int delay);
        int          o;
        logic        ill;
        logic        tmo;
        logic [63:0] exp_addr;
        o        = model_off(addr, f3);
        ill      = model_illegal(we, f3, addr);
        tmo      = (delay > TIMEOUT);
        exp_addr = addr & ~64'd7;

        @(negedge clk);
        chk("idle_ready", 64'(req_if.req_ready), 64'd1);
        chk("idle_busy", 64'(req_if.busy), 64'd0);
        chk("idle_resp_valid", 64'(req_if.resp_valid), 64'd0);
        chk("idle_resp_rdata", req_if.resp_rdata, 64'd0);
        chk("idle_resp_err", 64'(req_if.resp_err), 64'd0);
        req_if.req_valid = 1'b1;
        req_if.req_we    = we;
        req_if.req_func3 = f3;
        req_if.req_addr  = addr;
        req_if.req_wdata = wdata;

        @(negedge clk);
        if (ill) begin
            req_if.req_valid = 1'b0;
            chk("ill_resp_valid", 64'(req_if.resp_valid), 64'd1);
            chk("ill_resp_err", 64'(req_if.resp_err), 64'd1);
            chk("ill_resp_rdata", req_if.resp_rdata, 64'd0);
            chk("ill_mem_valid", 64'(mem_if.mem_valid), 64'd0);
            return;
        end

        chk("bus_we", 64'(mem_if.mem_we), 64'(we));
        chk("bus_wstrb", 64'(mem_if.mem_wstrb), we ? 64'(model_strobe(f3, o)) : 64'd0);
        if (we) chk("bus_wdata", mem_if.mem_wdata, wdata << (8 * o));

        for (int k = 0; k <= TIMEOUT; k++) begin
            chk("bus_mem_valid", 64'(mem_if.mem_valid), 64'd1);
            chk("bus_mem_addr", mem_if.mem_addr, exp_addr);
            chk("bus_resp_valid", 64'(req_if.resp_valid), 64'd0);
            // Requests offered while busy must be ignored
            req_if.req_valid = 1'b1;
            req_if.req_we    = 1'($urandom);
            req_if.req_func3 = 3'($urandom);
            req_if.req_addr  = {$urandom, $urandom};
            req_if.req_wdata = {$urandom, $urandom};
            if (k == delay) begin
                mem_if.mem_ready = 1'b1;
                mem_if.mem_rdata = rdata;
            end
            @(negedge clk);
            mem_if.mem_ready = 1'b0;
            mem_if.mem_rdata = {$urandom, $urandom};
            if (k == delay) break;
        end

        req_if.req_valid = 1'b0;
        chk("resp_valid", 64'(req_if.resp_valid), 64'd1);
        chk("resp_err", 64'(req_if.resp_err), 64'(tmo));
        chk("resp_rdata", req_if.resp_rdata,
            (tmo || we) ? 64'd0 : model_load(rdata, f3, o));
        chk("resp_mem_valid", 64'(mem_if.mem_valid), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst              = 1'b1;
        req_if.req_valid = 1'b0;
        req_if.req_we    = 1'b0;
        req_if.req_func3 = 3'd0;
        req_if.req_addr  = 64'd0;
        req_if.req_wdata = 64'd0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 64'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_req_ready", 64'(req_if.req_ready), 64'd0);
        chk("rst_busy", 64'(req_if.busy), 64'd0);
        chk("rst_mem_valid", 64'(mem_if.mem_valid), 64'd0);
        chk("rst_mem_we", 64'(mem_if.mem_we), 64'd0);
        chk("rst_mem_addr", mem_if.mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_if.mem_wdata, 64'd0);
        chk("rst_mem_wstrb", 64'(mem_if.mem_wstrb), 64'd0);
        chk("rst_resp_valid", 64'(req_if.resp_valid), 64'd0);
        chk("rst_resp_err", 64'(req_if.resp_err), 64'd0);
        chk("rst_resp_rdata", req_if.resp_rdata, 64'd0);
        rst = 1'b0;

        // Directed cases
        run_op(1'b0, 3'b000, 64'h1003, 64'd0, 64'h0000_0000_8000_0000, 2);   // lb
        run_op(1'b1, 3'b001, 64'h2006, 64'h1234, 64'd0, 0);                   // sh
        run_op(1'b0, 3'b110, 64'h10, 64'd0, 64'hDEAD_BEEF_89AB_CDEF, 1);      // lwu
        run_op(1'b0, 3'b010, 64'h10, 64'd0, 64'hDEAD_BEEF_89AB_CDEF, 1);      // lw
        run_op(1'b0, 3'b011, 64'h40, 64'd0, 64'h1122_3344_5566_7788, TIMEOUT + 1); // timeout
        run_op(1'b0, 3'b011, 64'h40, 64'd0, 64'h1122_3344_5566_7788, 3);      // 4th BUS cycle
        run_op(1'b0, 3'b011, 64'h48, 64'd0, 64'hA5A5_0000_FFFF_1234, TIMEOUT); // ready at limit
        run_op(1'b0, 3'b011, 64'h3004, 64'd0, 64'h0123_4567_89AB_CDEF, 0);    // ld misaligned
        run_op(1'b0, 3'b111, 64'h100, 64'd0, 64'd0, 0);                       // illegal load
        run_op(1'b1, 3'b100, 64'h100, 64'hFF, 64'd0, 0);                      // illegal store
        run_op(1'b1, 3'b011, 64'h208, 64'hCAFE_F00D_1234_5678, 64'd0, 0);     // sd
        run_op(1'b0, 3'b101, 64'h20E, 64'd0, 64'h8765_0000_0000_0000, 0);     // lhu top lanes

        // Reset in the middle of a bus cycle
        @(negedge clk);
        req_if.req_valid = 1'b1;
        req_if.req_we    = 1'b0;
        req_if.req_func3 = 3'b000;
        req_if.req_addr  = 64'h5000;
        @(negedge clk);
        req_if.req_valid = 1'b0;
        chk("rstmid_mem_valid_before", 64'(mem_if.mem_valid), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstmid_mem_valid", 64'(mem_if.mem_valid), 64'd0);
        chk("rstmid_busy", 64'(req_if.busy), 64'd0);
        chk("rstmid_resp_valid", 64'(req_if.resp_valid), 64'd0);
        chk("rstmid_req_ready", 64'(req_if.req_ready), 64'd0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("rstmid_no_resp", 64'(req_if.resp_valid), 64'd0);
        end
        run_op(1'b0, 3'b000, 64'h1007, 64'd0, 64'h7F00_0000_0000_0000, 1);   // fresh lb

        // Random operations
        for (int i = 0; i < 60; i++) begin
            run_op(1'($urandom), 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                   {$urandom, $urandom}, int'($urandom_range(0, TIMEOUT + 1)));
        end

        @(negedge clk);
        chk("end_ready", 64'(req_if.req_ready), 64'd1);
        chk("end_resp_rdata", req_if.resp_rdata, 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
